// File: rtl/md_unit_pkg.sv
// md_unit_pkg: operation encodings, FSM states and default latencies for md_unit.
// Optional feature macro: MD_MADD_EN (enables MADD/MADDU/MSUB/MSUBU, codes 7-10).
package md_unit_pkg;

  typedef enum logic [3:0] {
    OP_NONE  = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } md_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  // Long ops that take the multiplier latency.
  function automatic logic is_mult_class(input logic [3:0] op);
    logic r;
    r = (op == OP_MULT) || (op == OP_MULTU);
`ifdef MD_MADD_EN
    r = r || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return r;
  endfunction

  // Long ops that take the divider latency.
  function automatic logic is_div_class(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/md_unit_if.sv
// md_unit_if: E-stage request bus into the multiply/divide unit and its HI/LO/Busy results.
interface md_unit_if;
  logic        Start;
  logic [3:0]  MDOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        Busy;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (output Start, MDOp, A, B, input Busy, HI, LO);
  modport slave  (input Start, MDOp, A, B, output Busy, HI, LO);
endinterface

// File: rtl/md_calc.sv
// md_calc: combinational {HI,LO} result for the latched op and operands.
// Accumulate ops are only compiled when MD_MADD_EN is defined.
module md_calc
  import md_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] hi,
  input  logic [31:0] lo,
  output logic [63:0] result,
  output logic        write
);

  logic signed [63:0] a_sx;
  logic signed [63:0] b_sx;
  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic signed [32:0] a_33;
  logic signed [32:0] b_33;
  logic [31:0]        quot_s;
  logic [31:0]        rem_s;
  logic [31:0]        quot_u;
  logic [31:0]        rem_u;

  assign a_sx   = {{32{a[31]}}, a};
  assign b_sx   = {{32{b[31]}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = {32'd0, a} * {32'd0, b};

  // 33-bit signed divide so that -2^31 / -1 has a defined, wrapped result.
  assign a_33   = {a[31], a};
  assign b_33   = {b[31], b};
  assign quot_s = 32'(a_33 / b_33);
  assign rem_s  = 32'(a_33 % b_33);
  assign quot_u = a / b;
  assign rem_u  = a % b;

  // Select the result for the latched op; divide-by-zero leaves HI/LO alone.
  always_comb begin
    result = {hi, lo};
    write  = 1'b0;
    case (op)
      OP_MULT:  begin result = prod_s; write = 1'b1; end
      OP_MULTU: begin result = prod_u; write = 1'b1; end
      OP_DIV:   begin result = {rem_s, quot_s}; write = (b != 32'd0); end
      OP_DIVU:  begin result = {rem_u, quot_u}; write = (b != 32'd0); end
`ifdef MD_MADD_EN
      OP_MADD:  begin result = {hi, lo} + prod_s; write = 1'b1; end
      OP_MADDU: begin result = {hi, lo} + prod_u; write = 1'b1; end
      OP_MSUB:  begin result = {hi, lo} - prod_s; write = 1'b1; end
      OP_MSUBU: begin result = {hi, lo} - prod_u; write = 1'b1; end
`endif
      default:  begin result = {hi, lo}; write = 1'b0; end
    endcase
  end

endmodule

// File: rtl/md_unit.sv
// md_unit: MIPS multiply/divide unit. Holds HI/LO, runs long ops for a fixed
// number of cycles and raises Busy while one is in flight.
// Optional feature macro: MD_MADD_EN (accumulate ops, multiplier latency).
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic      Clk,
  input  logic      Reset,
  md_unit_if.slave  bus
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  md_state_e   state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [31:0] a_reg, a_next;
  logic [31:0] b_reg, b_next;
  logic [3:0]  op_reg, op_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic [63:0] calc_result;
  logic        calc_write;
  logic        accept_edge;

  md_calc u_calc (
    .op     (op_reg),
    .a      (a_reg),
    .b      (b_reg),
    .hi     (hi_reg),
    .lo     (lo_reg),
    .result (calc_result),
    .write  (calc_write)
  );

  // State, counter, latched request and HI/LO registers.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      op_reg    <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      op_reg    <= op_next;
      hi_reg    <= hi_next;
      lo_reg    <= lo_next;
    end
  end

  // Next-state: count down in RUN and commit on the last edge; that same edge
  // also accepts a new request so back-to-back ops lose no cycle. Any later
  // MTHI/MTLO on that edge overrides the commit, matching program order.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    op_next     = op_reg;
    hi_next     = hi_reg;
    lo_next     = lo_reg;
    accept_edge = 1'b0;

    case (state_reg)
      ST_IDLE: accept_edge = 1'b1;
      ST_RUN: begin
        cnt_next = cnt_reg - 1'b1;
        if (cnt_reg == CW'(1)) begin
          state_next  = ST_IDLE;
          accept_edge = 1'b1;
          if (calc_write) begin
            {hi_next, lo_next} = calc_result;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase

    if (accept_edge && bus.Start) begin
      if (is_mult_class(bus.MDOp) || is_div_class(bus.MDOp)) begin
        a_next     = bus.A;
        b_next     = bus.B;
        op_next    = bus.MDOp;
        cnt_next   = is_div_class(bus.MDOp) ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        state_next = ST_RUN;
      end else if (bus.MDOp == OP_MTHI) begin
        hi_next = bus.A;
      end else if (bus.MDOp == OP_MTLO) begin
        lo_next = bus.A;
      end
    end
  end

  assign bus.Busy = (state_reg == ST_RUN);
  assign bus.HI   = hi_reg;
  assign bus.LO   = lo_reg;

endmodule
